// File: rtl/instr_encoder_pkg.sv
// Shared instruction-format definitions used by the encoder and decode-side blocks.
package instr_encoder_pkg;

  // Instruction format selectors; 3'b110 and 3'b111 are illegal.
  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  // Base opcode constants.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // One buffered encoder result.
  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } enc_entry_t;

  // True when v[31:lsb] are all the same value, i.e. v fits a signed field of width lsb+1.
  function automatic logic all_equal(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << lsb;
    return ((v & mask) == mask) || ((v & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packing of instruction fields plus immediate range/format checking.
module imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic [31:0] raw;
  logic        range_ok;

  // Build the raw word per format and decide whether the immediate is representable.
  always_comb begin
    raw      = 32'h0;
    range_ok = 1'b1;
    case (fmt_i)
      FMT_I: begin
        raw      = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        range_ok = all_equal(imm_i, 11);
      end
      FMT_S: begin
        raw      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        range_ok = all_equal(imm_i, 11);
      end
      FMT_B: begin
        raw      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                    opcode_i};
        range_ok = all_equal(imm_i, 12) && !imm_i[0];
      end
      FMT_J: begin
        raw      = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        range_ok = all_equal(imm_i, 20) && !imm_i[0];
      end
      FMT_U: begin
        raw      = {imm_i[31:12], rd_i, opcode_i};
        range_ok = (imm_i[11:0] == 12'h0);
      end
      FMT_R: begin
        raw      = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        range_ok = 1'b1;
      end
      default: begin
        raw      = 32'h0;
        range_ok = 1'b0;
      end
    endcase
  end

  // Erroneous requests never leak a partially valid word.
  always_comb begin
    err_o   = !range_ok;
    instr_o = range_ok ? raw : 32'h0;
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs requests into words and buffers them in a 2-entry FIFO.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [31:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_err,
  output logic [ERRW-1:0] err_count
);

  logic [31:0]     pk_instr;
  logic            pk_err;
  logic            push;
  logic            pop;
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [ERRW-1:0] err_count_q, err_count_d;
  enc_entry_t      mem_q [2];
  enc_entry_t      head;

  imm_pack u_imm_pack (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .instr_o  (pk_instr),
    .err_o    (pk_err)
  );

  // Handshake and head-of-queue outputs; ready ignores out_ready so a full FIFO never pushes.
  always_comb begin
    in_ready  = !reset && (count_q < 2'd2);
    out_valid = (count_q != 2'd0);
    head      = mem_q[rd_ptr_q];
    out_instr = out_valid ? head.instr : 32'h0;
    out_err   = out_valid ? head.err : 1'b0;
    err_count = err_count_q;
  end

  // Next occupancy and saturating error count.
  always_comb begin
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    count_d     = count_q;
    err_count_d = err_count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push && pk_err && (err_count_q != {ERRW{1'b1}})) begin
      err_count_d = err_count_q + {{(ERRW-1){1'b0}}, 1'b1};
    end
  end

  // FIFO storage, pointers and counters; reset discards all buffered entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      err_count_q <= '0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{err: pk_err, instr: pk_instr};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q     <= count_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder against a behavioural queue model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  instr_encoder #(.ERRW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } ent_t;

  ent_t q[$];
  int   model_errs = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference encoder: range checks as signed arithmetic bounds, fields placed by shifts.
  function automatic ent_t ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] imm);
    ent_t e;
    int s;
    logic ok;
    logic [31:0] w, b_op, b_rd, b_r1, b_r2, b_f3, b_f7;
    s    = $signed(imm);
    b_op = 32'(op);
    b_rd = 32'(rd) << 7;
    b_f3 = 32'(f3) << 12;
    b_r1 = 32'(rs1) << 15;
    b_r2 = 32'(rs2) << 20;
    b_f7 = 32'(f7) << 25;
    ok   = 1'b1;
    w    = 32'h0;
    case (fmt)
      3'd0: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((imm & 32'hFFF) << 20) | b_r1 | b_f3 | b_rd | b_op;
      end
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | b_r2 | b_r1 | b_f3 | ((imm & 32'h1F) << 7) | b_op;
      end
      3'd2: begin
        ok = (s >= -4096) && (s <= 4095) && ((s % 2) == 0);
        w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | b_r2 | b_r1 |
             b_f3 | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | b_op;
      end
      3'd3: begin
        ok = (s >= -1048576) && (s <= 1048575) && ((s % 2) == 0);
        w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | b_rd | b_op;
      end
      3'd4: begin
        ok = ((imm % 4096) == 0);
        w  = (imm & 32'hFFFF_F000) | b_rd | b_op;
      end
      3'd5: w = b_f7 | b_r2 | b_r1 | b_f3 | b_rd | b_op;
      default: ok = 1'b0;
    endcase
    e.instr = ok ? w : 32'h0;
    e.err   = !ok;
    e.fmt   = fmt;
    e.imm   = imm;
    return e;
  endfunction

  // Decode-side sign extender model: recover the immediate from an encoded word.
  function automatic logic [31:0] sign_extend(input logic [2:0] sel_ext, input logic [31:0] w);
    case (sel_ext)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return {w[31:12], 12'h0};
    endcase
  endfunction

  // Check all outputs against the model, then advance one clock and update the model.
  task automatic cycle();
    ent_t h;
    ent_t e;
    logic push, pop;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("err_count", 32'(err_count), 32'(model_errs));
    if (q.size() > 0) begin
      h = q[0];
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_instr", out_instr, h.instr);
      chk("out_err", 32'(out_err), 32'(h.err));
      if (!h.err && (h.fmt < 3'd5)) chk("sext_roundtrip", sign_extend(h.fmt, out_instr), h.imm);
    end else begin
      chk("out_valid_empty", 32'(out_valid), 32'd0);
      chk("out_instr_empty", out_instr, 32'h0);
      chk("out_err_empty", 32'(out_err), 32'd0);
    end
    push = in_valid && (q.size() < 2);
    pop  = (q.size() > 0) && out_ready;
    e = ref_encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(e);
      if (e.err && model_errs < 255) model_errs = model_errs + 1;
    end
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  f;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // I-type, all-ones immediate, one-cycle latency
    set_req(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("i_valid_lat1", 32'(out_valid), 32'd1);
    chk("i_word", out_instr, 32'hFFF0_0093);
    chk("i_err", 32'(out_err), 32'd0);
    out_ready = 1'b1;
    cycle();

    // B-type negative even offset
    set_req(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8);
    in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk("b_word", out_instr, 32'hFE20_8CE3);
    chk("b_err", 32'(out_err), 32'd0);
    out_ready = 1'b1;
    cycle();

    // Out-of-range I and odd J are both rejected
    out_ready = 1'b0; in_valid = 1'b1;
    set_req(3'd0, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    cycle();
    set_req(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0003);
    cycle();
    in_valid = 1'b0;
    chk("err_head_instr", out_instr, 32'h0);
    chk("err_head_flag", 32'(out_err), 32'd1);
    chk("err_count_2", 32'(err_count), 32'd2);
    out_ready = 1'b1;
    cycle();
    chk("err_second_instr", out_instr, 32'h0);
    chk("err_second_flag", 32'(out_err), 32'd1);
    cycle();

    // Back-to-back with a stalled consumer: third request waits
    out_ready = 1'b0; in_valid = 1'b1;
    set_req(3'd5, 7'b0110011, 5'd5, 5'd6, 5'd7, 3'd1, 7'd0, 32'h0);
    cycle();
    set_req(3'd4, 7'b0110111, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    cycle();
    set_req(3'd1, 7'b0100011, 5'd0, 5'd9, 5'd10, 3'd2, 7'd0, 32'hFFFF_F800);
    cycle();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    // Mid-cycle reset with two entries buffered
    out_ready = 1'b0; in_valid = 1'b1;
    set_req(3'd6, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    cycle();
    cycle();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_errs", 32'(err_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    q.delete();
    model_errs = 0;
    #1 reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    cycle();

    // Randomised traffic, mostly in-range immediates
    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      f = 3'($urandom_range(0, 7));
      case (f)
        3'd0, 3'd1: in_imm = {{20{r[11]}}, r[11:0]};
        3'd2:       in_imm = {{19{r[12]}}, r[12:1], 1'b0};
        3'd3:       in_imm = {{11{r[20]}}, r[20:1], 1'b0};
        3'd4:       in_imm = {r[31:12], 12'h0};
        default:    in_imm = r;
      endcase
      if ($urandom_range(0, 7) == 0) in_imm = $urandom();
      in_fmt = f;
      in_opcode = 7'($urandom()); in_rd = 5'($urandom()); in_rs1 = 5'($urandom());
      in_rs2 = 5'($urandom()); in_funct3 = 3'($urandom()); in_funct7 = 7'($urandom());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // Saturation of the error counter
    in_valid = 1'b1; out_ready = 1'b1;
    set_req(3'd7, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    for (int i = 0; i < 300; i++) cycle();
    in_valid = 1'b0;
    cycle();
    chk("err_count_sat", 32'(err_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ERRW, 8, width of the saturating error counter.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  in  1  request present.
REQ-005 Port: in_ready  out  1  encoder can accept a request.
REQ-006 Port: in_fmt  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 R, 110/111 illegal.
REQ-007 Port: in_opcode  in  7  opcode field.
REQ-008 Port: in_rd / in_rs1 / in_rs2  in  5 each  register fields.
REQ-009 Port: in_funct3  in  3; in_funct7  in  7  function fields.
REQ-010 Port: in_imm  in  32  sign-extended immediate value to pack.
REQ-011 Port: out_valid  out  1  head entry present.
REQ-012 Port: out_ready  in  1  consumer takes head entry.
REQ-013 Port: out_instr  out  32  encoded instruction word.
REQ-014 Port: out_err  out  1  head entry failed its range/format check.
REQ-015 Port: err_count  out  ERRW  count of accepted erroneous requests.

Function
REQ-016 Accept occurs on a rising edge with in_valid && in_ready; pop occurs on a rising edge with out_valid && out_ready.
REQ-017 Encoded word and error flag are written into a 2-entry FIFO on accept; out_valid rises the cycle after accept (latency 1).
REQ-018 in_ready = !reset && (count < 2); in_ready does not depend on out_ready (no push when full, even if popping).
REQ-019 Simultaneous push and pop with count 1 leaves count 1; FIFO order is strictly preserved.
REQ-020 out_instr and out_err show the head entry; both are 0 when the FIFO is empty.
REQ-021 Packing, fields listed MSB to LSB: I {imm[11:0], rs1, f3, rd, op}; S {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
REQ-022 Packing: B {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; J {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-023 Packing: U {imm[31:12], rd, op}; R {f7, rs2, rs1, f3, rd, op}.
REQ-024 Range rules: I/S require imm[31:11] all equal; B requires imm[31:12] all equal and imm[0]=0.
REQ-025 Range rules: J requires imm[31:20] all equal and imm[0]=0; U requires imm[11:0]=0; R ignores in_imm.
REQ-026 A range failure or an illegal in_fmt stores out_instr=32'h0 with out_err=1.
REQ-027 err_count increments by 1 on each accepted erroneous request and saturates at all-ones.

Reset
REQ-028 Asserting reset asynchronously sets count, read and write pointers, and err_count to 0; out_valid=0, out_instr=0, out_err=0, in_ready=0.
REQ-029 Reset asserted mid-operation discards all buffered entries; in_ready=1 on the first cycle after deassertion.

Structure
REQ-030 The format codes FMT_I..FMT_R and the opcode constants live in the shared formats package/header that the decode-side blocks also use.
REQ-031 One combinational sub-module, imm_pack, performs packing and range checking; the FIFO, counter, and handshake logic stay in instr_encoder.

Verification
REQ-032 I fmt, op 0010011, rd=1, rs1=0, f3=0, imm=FFFFFFFF -> out_instr=FFF00093, out_err=0, out_valid one cycle after accept.
REQ-033 B fmt, op 1100011, rs1=1, rs2=2, f3=0, imm=FFFFFFF8 -> out_instr=FE208CE3, out_err=0.
REQ-034 I fmt, imm=00000800; then J fmt, imm=00000003 -> both entries out_instr=0, out_err=1; err_count=2.
REQ-035 out_ready=0, three back-to-back requests -> two accepted, in_ready=0 holds the third; raise out_ready -> three words drain in order.
REQ-036 Two entries buffered, pulse reset mid-cycle -> out_valid=0 and err_count=0 immediately; in_ready=1 after release.
REQ-037 Random in-range I/S/B/J/U immediates, output passed through sign_extender with the matching sel_ext -> result equals in_imm.
